// File: rtl/j1_io_bridge_master_if.sv
// Byte-stream and J1 I/O bus signals of the debug/loader bridge.
// The master modport is the bridge side; slave is the UART/arbiter/peripheral side.
interface j1_io_bridge_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        io_rd;
    logic        io_wr;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_gnt, io_din,
        output rx_ready, tx_data, tx_valid, bus_req, io_addr, io_dout, io_rd, io_wr
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_gnt, io_din,
        input  rx_ready, tx_data, tx_valid, bus_req, io_addr, io_dout, io_rd, io_wr
    );
endinterface

// File: rtl/j1_io_bridge_master.sv
// Byte-stream to J1 I/O bus initiator: parses 'W'/'R' command frames, issues a single
// io_wr/io_rd once the arbiter grants the bus, and streams the response bytes back.
module j1_io_bridge_master #(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 50000
) (
    input logic                   clk,
    input logic                   rst,
    j1_io_bridge_master_if.master bus
);
    localparam int unsigned TO_W  = $clog2(TIMEOUT);
    localparam int unsigned LAT_W = 4;
    localparam logic [7:0]  OP_W    = 8'h57;
    localparam logic [7:0]  OP_R    = 8'h52;
    localparam logic [7:0]  RSP_K   = 8'h4B;
    localparam logic [7:0]  RSP_ERR = 8'h3F;

    typedef enum logic [3:0] {
        IDLE, GET_AH, GET_AL, GET_DH, GET_DL, REQ, STROBE, WAIT_RD, TX_B0, TX_B1
    } state_t;

    state_t state, state_next;

    logic [7:0]       op_q, ah_q, al_q, dh_q, dl_q;
    logic [TO_W-1:0]  to_cnt;
    logic [LAT_W-1:0] lat_cnt;

    logic        rx_ready_q, tx_valid_q, bus_req_q, io_rd_q, io_wr_q;
    logic [7:0]  tx_data_q;
    logic [15:0] io_addr_q, io_dout_q;

    logic       accept_c, in_get_c, to_expired_c, lat_done_c, tx_load_c;
    logic [7:0] tx_byte_c;

    assign accept_c     = bus.rx_valid & rx_ready_q;
    assign in_get_c     = state inside {GET_AH, GET_AL, GET_DH, GET_DL};
    assign to_expired_c = (to_cnt == TO_W'(TIMEOUT - 1));
    assign lat_done_c   = (lat_cnt == LAT_W'(RD_LAT - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state and response byte selection
    always_comb begin
        state_next = state;
        tx_load_c  = 1'b0;
        tx_byte_c  = 8'h00;
        case (state)
            IDLE: if (accept_c) begin
                if (bus.rx_data == OP_W || bus.rx_data == OP_R) begin
                    state_next = GET_AH;
                end else begin
                    state_next = TX_B0;
                    tx_load_c  = 1'b1;
                    tx_byte_c  = RSP_ERR;
                end
            end
            GET_AH: if (accept_c) state_next = GET_AL;
                    else if (to_expired_c) state_next = IDLE;
            GET_AL: if (accept_c) state_next = (op_q == OP_R) ? REQ : GET_DH;
                    else if (to_expired_c) state_next = IDLE;
            GET_DH: if (accept_c) state_next = GET_DL;
                    else if (to_expired_c) state_next = IDLE;
            GET_DL: if (accept_c) state_next = REQ;
                    else if (to_expired_c) state_next = IDLE;
            REQ:    if (bus.bus_gnt) state_next = STROBE;
            STROBE: if (op_q == OP_W) begin
                        state_next = TX_B0;
                        tx_load_c  = 1'b1;
                        tx_byte_c  = RSP_K;
                    end else begin
                        state_next = WAIT_RD;
                    end
            WAIT_RD: if (lat_done_c) begin
                        state_next = TX_B0;
                        tx_load_c  = 1'b1;
                        tx_byte_c  = bus.io_din[15:8];
                    end
            TX_B0:  if (bus.tx_ready) begin
                        if (op_q == OP_R) begin
                            state_next = TX_B1;
                            tx_load_c  = 1'b1;
                            tx_byte_c  = dl_q;
                        end else begin
                            state_next = IDLE;
                        end
                    end
            TX_B1:  if (bus.tx_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame field capture, inter-byte timeout and read-latency counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= 8'h00;
            ah_q    <= 8'h00;
            al_q    <= 8'h00;
            dh_q    <= 8'h00;
            dl_q    <= 8'h00;
            to_cnt  <= '0;
            lat_cnt <= '0;
        end else begin
            if (accept_c) begin
                case (state)
                    IDLE:    op_q <= bus.rx_data;
                    GET_AH:  ah_q <= bus.rx_data;
                    GET_AL:  al_q <= bus.rx_data;
                    GET_DH:  dh_q <= bus.rx_data;
                    GET_DL:  dl_q <= bus.rx_data;
                    default: ;
                endcase
            end
            if (state == WAIT_RD && lat_done_c) dl_q <= bus.io_din[7:0];
            to_cnt  <= (in_get_c && !accept_c) ? to_cnt + TO_W'(1) : '0;
            lat_cnt <= (state == WAIT_RD) ? lat_cnt + LAT_W'(1) : '0;
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            bus_req_q  <= 1'b0;
            io_rd_q    <= 1'b0;
            io_wr_q    <= 1'b0;
            io_addr_q  <= 16'h0000;
            io_dout_q  <= 16'h0000;
        end else begin
            rx_ready_q <= state_next inside {IDLE, GET_AH, GET_AL, GET_DH, GET_DL};
            tx_valid_q <= state_next inside {TX_B0, TX_B1};
            bus_req_q  <= state_next inside {REQ, STROBE, WAIT_RD};
            io_wr_q    <= (state_next == STROBE) && (op_q == OP_W);
            io_rd_q    <= (state_next == STROBE) && (op_q == OP_R);
            if (tx_load_c) tx_data_q <= tx_byte_c;
            // The final frame byte is still on rx_data when REQ is entered
            if (state == GET_AL && state_next == REQ) begin
                io_addr_q <= {ah_q, bus.rx_data};
            end else if (state == GET_DL && state_next == REQ) begin
                io_addr_q <= {ah_q, al_q};
                io_dout_q <= {dh_q, bus.rx_data};
            end else if (state_next == IDLE) begin
                io_addr_q <= 16'h0000;
                io_dout_q <= 16'h0000;
            end
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.bus_req  = bus_req_q;
    assign bus.io_rd    = io_rd_q;
    assign bus.io_wr    = io_wr_q;
    assign bus.io_addr  = io_addr_q;
    assign bus.io_dout  = io_dout_q;
endmodule

// File: tb/tb_j1_io_bridge_master.sv
// Directed bench for j1_io_bridge_master: write/read frames, bad opcode, timeout,
// grant and tx back-pressure, and reset in the middle of a read.
module tb_j1_io_bridge_master;
    localparam int unsigned RD_LAT  = 1;
    localparam int unsigned TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;

    j1_io_bridge_master_if bif();

    j1_io_bridge_master #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    int          wr_cnt, rd_cnt, breq_cycles, strobe_cyc, txv_cyc;
    logic [15:0] wr_addr, wr_data, rd_addr;
    logic [7:0]  tx_q[$];
    logic        prev_txv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bif.io_wr) begin wr_cnt++; wr_addr = bif.io_addr; wr_data = bif.io_dout; strobe_cyc = cyc; end
        if (bif.io_rd) begin rd_cnt++; rd_addr = bif.io_addr; strobe_cyc = cyc; end
        if (bif.bus_req) breq_cycles++;
        if (bif.tx_valid && !prev_txv && txv_cyc < 0) txv_cyc = cyc;
        if (bif.tx_valid && bif.tx_ready) tx_q.push_back(bif.tx_data);
        prev_txv = bif.tx_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        wr_cnt = 0; rd_cnt = 0; breq_cycles = 0; strobe_cyc = -1; txv_cyc = -1;
        wr_addr = 16'h0; wr_data = 16'h0; rd_addr = 16'h0;
        tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n = 0;
        logic done = 1'b0;
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (bif.rx_ready) begin acc_cyc = cyc; done = 1'b1; end
            @(posedge clk); #1;
            n++;
        end
        bif.rx_valid = 1'b0;
        if (!done) begin checks++; failures++; $display("FAIL rx_accept byte=%h never accepted", b); end
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_q.size() < n && k < 300) begin step(); k++; end
        checks++;
        if (tx_q.size() < n) begin failures++; $display("FAIL tx_wait got=%0d bytes exp=%0d", tx_q.size(), n); end
        repeat (4) step();
    endtask

    task automatic test_reset();
        bif.rx_data = 8'h00; bif.rx_valid = 1'b0; bif.tx_ready = 1'b0;
        bif.bus_gnt = 1'b0; bif.io_din = 16'h0000;
        clear_mon();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bif.rx_ready, bif.tx_valid, bif.bus_req, bif.io_rd, bif.io_wr} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {bif.rx_ready, bif.tx_valid, bif.bus_req, bif.io_rd, bif.io_wr});
        end
        checks++;
        if ({bif.io_addr, bif.io_dout, bif.tx_data} !== 40'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {bif.io_addr, bif.io_dout, bif.tx_data});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", bif.rx_ready); end
        step();
    endtask

    task automatic test_write();
        clear_mon();
        bif.bus_gnt = 1'b1; bif.tx_ready = 1'b1;
        send_byte(8'h57); send_byte(8'h67); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
        wait_tx(1);
        checks++; if (wr_cnt !== 1 || rd_cnt !== 0) begin failures++; $display("FAIL wr_strobes got wr=%0d rd=%0d exp wr=1 rd=0", wr_cnt, rd_cnt); end
        checks++; if (wr_addr !== 16'h6700) begin failures++; $display("FAIL wr_addr got=%h exp=6700", wr_addr); end
        checks++; if (wr_data !== 16'h1234) begin failures++; $display("FAIL wr_data got=%h exp=1234", wr_data); end
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin failures++; $display("FAIL wr_resp got=%0d bytes first=%h exp 1 byte 4b", tx_q.size(), tx_q[0]); end
        checks++; if (strobe_cyc - acc_cyc != 2) begin failures++; $display("FAIL wr_strobe_lat got=%0d exp=2", strobe_cyc - acc_cyc); end
        checks++; if (txv_cyc - acc_cyc != 3) begin failures++; $display("FAIL wr_tx_lat got=%0d exp=3", txv_cyc - acc_cyc); end
        checks++; if (breq_cycles != 2) begin failures++; $display("FAIL wr_bus_req_cycles got=%0d exp=2", breq_cycles); end
    endtask

    task automatic test_read();
        clear_mon();
        bif.io_din = 16'hBEEF;
        send_byte(8'h52); send_byte(8'h69); send_byte(8'h00);
        wait_tx(2);
        checks++; if (rd_cnt !== 1 || wr_cnt !== 0) begin failures++; $display("FAIL rd_strobes got rd=%0d wr=%0d exp rd=1 wr=0", rd_cnt, wr_cnt); end
        checks++; if (rd_addr !== 16'h6900) begin failures++; $display("FAIL rd_addr got=%h exp=6900", rd_addr); end
        checks++; if (tx_q.size() != 2 || tx_q[0] !== 8'hBE || tx_q[1] !== 8'hEF) begin failures++; $display("FAIL rd_resp got=%0d bytes %h %h exp be ef", tx_q.size(), tx_q[0], tx_q[1]); end
        checks++; if (strobe_cyc - acc_cyc != 2) begin failures++; $display("FAIL rd_strobe_lat got=%0d exp=2", strobe_cyc - acc_cyc); end
        checks++; if (txv_cyc - acc_cyc != 3 + RD_LAT) begin failures++; $display("FAIL rd_tx_lat got=%0d exp=%0d", txv_cyc - acc_cyc, 3 + RD_LAT); end
        checks++; if (breq_cycles != 3) begin failures++; $display("FAIL rd_bus_req_cycles got=%0d exp=3", breq_cycles); end
    endtask

    task automatic test_bad_opcode();
        clear_mon();
        send_byte(8'h41);
        wait_tx(1);
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h3F) begin failures++; $display("FAIL bad_resp got=%0d bytes first=%h exp 1 byte 3f", tx_q.size(), tx_q[0]); end
        checks++; if (wr_cnt + rd_cnt + breq_cycles != 0) begin failures++; $display("FAIL bad_bus_activity got wr=%0d rd=%0d req=%0d exp 0", wr_cnt, rd_cnt, breq_cycles); end
        clear_mon();
        bif.io_din = 16'h1357;
        send_byte(8'h52); send_byte(8'h6A); send_byte(8'h02);
        wait_tx(2);
        checks++; if (rd_cnt !== 1 || rd_addr !== 16'h6A02) begin failures++; $display("FAIL bad_next_rd got cnt=%0d addr=%h exp 1 6a02", rd_cnt, rd_addr); end
        checks++; if (tx_q.size() != 2 || tx_q[0] !== 8'h13 || tx_q[1] !== 8'h57) begin failures++; $display("FAIL bad_next_resp got=%0d bytes %h %h exp 13 57", tx_q.size(), tx_q[0], tx_q[1]); end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_byte(8'h57); send_byte(8'h67);
        repeat (TIMEOUT + 5) step();
        @(negedge clk);
        checks++; if (tx_q.size() != 0 || breq_cycles != 0) begin failures++; $display("FAIL to_silent got tx=%0d req=%0d exp 0 0", tx_q.size(), breq_cycles); end
        checks++; if (bif.rx_ready !== 1'b1) begin failures++; $display("FAIL to_rx_ready got=%b exp=1", bif.rx_ready); end
        step();
        bif.io_din = 16'hA5C3;
        send_byte(8'h52); send_byte(8'h70); send_byte(8'h05);
        wait_tx(2);
        checks++; if (rd_cnt !== 1 || wr_cnt !== 0 || rd_addr !== 16'h7005) begin failures++; $display("FAIL to_next_rd got rd=%0d wr=%0d addr=%h exp 1 0 7005", rd_cnt, wr_cnt, rd_addr); end
        checks++; if (tx_q.size() != 2 || tx_q[0] !== 8'hA5 || tx_q[1] !== 8'hC3) begin failures++; $display("FAIL to_next_resp got=%0d bytes %h %h exp a5 c3", tx_q.size(), tx_q[0], tx_q[1]); end
        // A gap shorter than the timeout must not break the frame
        clear_mon();
        send_byte(8'h57); send_byte(8'h6B);
        repeat (TIMEOUT - 10) step();
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        wait_tx(1);
        checks++; if (wr_cnt !== 1 || wr_addr !== 16'h6B00 || wr_data !== 16'h1122) begin failures++; $display("FAIL gap_wr got cnt=%0d addr=%h data=%h exp 1 6b00 1122", wr_cnt, wr_addr, wr_data); end
    endtask

    task automatic test_gnt_stall();
        int k;
        clear_mon();
        bif.bus_gnt = 1'b0; bif.tx_ready = 1'b0;
        send_byte(8'h57); send_byte(8'h6C); send_byte(8'h10); send_byte(8'hAB); send_byte(8'hCD);
        repeat (20) step();
        @(negedge clk);
        checks++; if (wr_cnt != 0 || bif.bus_req !== 1'b1) begin failures++; $display("FAIL gnt_wait got wr=%0d req=%b exp 0 1", wr_cnt, bif.bus_req); end
        step();
        bif.bus_gnt = 1'b1;
        k = 0;
        while (!bif.tx_valid && k < 20) begin step(); k++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bif.tx_valid !== 1'b1 || bif.tx_data !== 8'h4B) begin failures++; $display("FAIL tx_hold cyc%0d got v=%b d=%h exp 1 4b", i, bif.tx_valid, bif.tx_data); end
        end
        checks++; if (wr_cnt != 1 || bif.bus_req !== 1'b0) begin failures++; $display("FAIL gnt_strobe got wr=%0d req=%b exp 1 0", wr_cnt, bif.bus_req); end
        step();
        bif.tx_ready = 1'b1;
        repeat (5) step();
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin failures++; $display("FAIL stall_resp got=%0d bytes first=%h exp 1 byte 4b", tx_q.size(), tx_q[0]); end
        checks++; if (wr_addr !== 16'h6C10 || wr_data !== 16'hABCD) begin failures++; $display("FAIL stall_wr got addr=%h data=%h exp 6c10 abcd", wr_addr, wr_data); end
        // Grant withdrawn after the read strobe; the response must still complete
        clear_mon();
        bif.tx_ready = 1'b0;
        bif.io_din = 16'h0F1E;
        send_byte(8'h52); send_byte(8'h6D); send_byte(8'h20);
        k = 0;
        while (rd_cnt == 0 && k < 50) begin step(); k++; end
        bif.bus_gnt = 1'b0;
        repeat (6) step();
        @(negedge clk);
        checks++; if (bif.tx_valid !== 1'b1 || bif.tx_data !== 8'h0F) begin failures++; $display("FAIL gnt_loss_hold got v=%b d=%h exp 1 0f", bif.tx_valid, bif.tx_data); end
        step();
        bif.tx_ready = 1'b1;
        wait_tx(2);
        checks++; if (tx_q.size() != 2 || tx_q[0] !== 8'h0F || tx_q[1] !== 8'h1E || rd_cnt != 1) begin failures++; $display("FAIL gnt_loss_resp got=%0d bytes %h %h rd=%0d exp 0f 1e 1", tx_q.size(), tx_q[0], tx_q[1], rd_cnt); end
        bif.bus_gnt = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        int k = 0;
        clear_mon();
        bif.io_din = 16'h2222;
        send_byte(8'h52); send_byte(8'h65); send_byte(8'h00);
        while (rd_cnt == 0 && k < 50) begin step(); k++; end
        rst = 1'b0;
        #1;
        checks++; if ({bif.rx_ready, bif.tx_valid, bif.bus_req, bif.io_rd, bif.io_wr} !== 5'b0) begin failures++; $display("FAIL async_rst_ctrl got=%b exp=00000", {bif.rx_ready, bif.tx_valid, bif.bus_req, bif.io_rd, bif.io_wr}); end
        checks++; if ({bif.io_addr, bif.io_dout, bif.tx_data} !== 40'h0) begin failures++; $display("FAIL async_rst_data got=%h exp=0", {bif.io_addr, bif.io_dout, bif.tx_data}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bif.tx_valid, bif.io_rd, bif.io_wr, bif.bus_req} !== 4'b0) begin failures++; $display("FAIL post_rst cyc%0d got=%b exp=0000", i, {bif.tx_valid, bif.io_rd, bif.io_wr, bif.bus_req}); end
        end
        checks++; if (tx_q.size() != 0 || rd_cnt != 1) begin failures++; $display("FAIL rst_abort got tx=%0d rd=%0d exp 0 1", tx_q.size(), rd_cnt); end
        step();
        clear_mon();
        bif.io_din = 16'h5AA5;
        send_byte(8'h52); send_byte(8'h64); send_byte(8'h00);
        wait_tx(2);
        checks++; if (rd_cnt != 1 || rd_addr !== 16'h6400) begin failures++; $display("FAIL rst_next_rd got cnt=%0d addr=%h exp 1 6400", rd_cnt, rd_addr); end
        checks++; if (tx_q.size() != 2 || tx_q[0] !== 8'h5A || tx_q[1] !== 8'hA5) begin failures++; $display("FAIL rst_next_resp got=%0d bytes %h %h exp 5a a5", tx_q.size(), tx_q[0], tx_q[1]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_timeout();
        test_gnt_stall();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
